// File: rtl/vector_matrix_mult.sv
// vector_matrix_mult: result[j] = (sum_i v[i]*W[i][j]) >>> FRACTION_WIDTH.
// Operands are captured independently through valid/ready slots. One matrix
// row is consumed per cycle with all columns accumulated in parallel. The
// result and overflow flag are held until the consumer accepts them.
module vector_matrix_mult #(
   parameter int VECTOR_LEN        = 4,
   parameter int MATRIX_WIDTH      = 3,
   parameter int A_CELL_WIDTH      = 8,
   parameter int B_CELL_WIDTH      = 8,
   parameter int RESULT_CELL_WIDTH = 8,
   parameter int FRACTION_WIDTH    = 4
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]           v,
   input  logic                                         v_valid,
   output logic                                         v_ready,
   input  logic [VECTOR_LEN*MATRIX_WIDTH*B_CELL_WIDTH-1:0] w,
   input  logic                                         w_valid,
   output logic                                         w_ready,
   output logic [MATRIX_WIDTH*RESULT_CELL_WIDTH-1:0]    result,
   output logic                                         result_valid,
   input  logic                                         result_ready,
   output logic                                         error
);

   // Wide enough that summing VECTOR_LEN full-scale products cannot wrap.
   localparam int ACC_WIDTH  = A_CELL_WIDTH + B_CELL_WIDTH + $clog2(VECTOR_LEN) + 1;
   localparam int CNT_WIDTH  = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
   localparam int PROD_WIDTH = A_CELL_WIDTH + B_CELL_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_reg, state_next;

   logic [VECTOR_LEN*A_CELL_WIDTH-1:0]              v_buf_reg;
   logic [VECTOR_LEN*MATRIX_WIDTH*B_CELL_WIDTH-1:0] w_buf_reg;
   logic                                            v_set_reg;
   logic                                            w_set_reg;
   logic [CNT_WIDTH-1:0]                            counter_reg;
   logic signed [ACC_WIDTH-1:0]                     acc_reg [MATRIX_WIDTH];
   logic [MATRIX_WIDTH*RESULT_CELL_WIDTH-1:0]       result_reg;
   logic                                            error_reg;

   logic signed [ACC_WIDTH-1:0]                     acc_sum [MATRIX_WIDTH];
   logic [MATRIX_WIDTH*RESULT_CELL_WIDTH-1:0]       result_calc;
   logic [MATRIX_WIDTH-1:0]                         fit;
   logic signed [A_CELL_WIDTH-1:0]                  a_elem;
   logic                                            last_row;
   logic                                            v_take;
   logic                                            w_take;

   assign last_row = (counter_reg == CNT_WIDTH'(VECTOR_LEN - 1));
   assign v_take   = v_valid && v_ready;
   assign w_take   = w_valid && w_ready;

   // Vector element for the row currently being accumulated.
   assign a_elem = v_buf_reg[int'(counter_reg)*A_CELL_WIDTH +: A_CELL_WIDTH];

   // Per-column multiply-accumulate, post-accumulation scaling and range check.
   genvar gi;
   generate
      for (gi = 0; gi < MATRIX_WIDTH; gi++) begin : g_col
         logic signed [B_CELL_WIDTH-1:0] b_elem;
         logic signed [PROD_WIDTH-1:0]   product;
         logic signed [ACC_WIDTH-1:0]    shifted;

         assign b_elem = w_buf_reg[(int'(counter_reg)*MATRIX_WIDTH + gi)*B_CELL_WIDTH +: B_CELL_WIDTH];
         assign product = a_elem * b_elem;
         assign acc_sum[gi] = acc_reg[gi] + ACC_WIDTH'(product);
         assign shifted = acc_sum[gi] >>> FRACTION_WIDTH;
         // Fits when every bit above the result sign bit copies that sign bit.
         assign fit[gi] = (&shifted[ACC_WIDTH-1:RESULT_CELL_WIDTH-1]) |
                          ~(|shifted[ACC_WIDTH-1:RESULT_CELL_WIDTH-1]);
         assign result_calc[gi*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH] =
                shifted[RESULT_CELL_WIDTH-1:0];
      end
   endgenerate

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: wait for both operands, run VECTOR_LEN rows, hold result.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (v_set_reg && w_set_reg) state_next = CALC;
         CALC: if (last_row)               state_next = DONE;
         DONE: if (result_ready)           state_next = IDLE;
         default:                          state_next = IDLE;
      endcase
   end

   // Handshake outputs derived from slot flags and state.
   always_comb begin
      v_ready      = !v_set_reg;
      w_ready      = !w_set_reg;
      result_valid = (state_reg == DONE);
   end

   // Operand slots, accumulators, row counter and held result.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_buf_reg   <= '0;
         w_buf_reg   <= '0;
         v_set_reg   <= 1'b0;
         w_set_reg   <= 1'b0;
         counter_reg <= '0;
         result_reg  <= '0;
         error_reg   <= 1'b0;
         for (int j = 0; j < MATRIX_WIDTH; j++) begin
            acc_reg[j] <= '0;
         end
      end else begin
         if (v_take) begin
            v_buf_reg <= v;
            v_set_reg <= 1'b1;
         end
         if (w_take) begin
            w_buf_reg <= w;
            w_set_reg <= 1'b1;
         end
         case (state_reg)
            IDLE: begin
               if (v_set_reg && w_set_reg) begin
                  counter_reg <= '0;
                  error_reg   <= 1'b0;
                  for (int j = 0; j < MATRIX_WIDTH; j++) begin
                     acc_reg[j] <= '0;
                  end
               end
            end
            CALC: begin
               counter_reg <= counter_reg + 1'b1;
               for (int j = 0; j < MATRIX_WIDTH; j++) begin
                  acc_reg[j] <= acc_sum[j];
               end
               if (last_row) begin
                  result_reg <= result_calc;
                  error_reg  <= ~(&fit);
               end
            end
            DONE: begin
               if (result_ready) begin
                  v_set_reg <= 1'b0;
                  w_set_reg <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign result = result_reg;
   assign error  = error_reg;

endmodule

// File: tb/tb_vector_matrix_mult.sv
// Directed bench for vector_matrix_mult with default parameters
// (4 rows, 3 columns, 8-bit cells, 4 fraction bits).
module tb_vector_matrix_mult;

   localparam int VL = 4;

   logic        clk;
   logic        rst;
   logic [31:0] v;
   logic        v_valid;
   logic        v_ready;
   logic [95:0] w;
   logic        w_valid;
   logic        w_ready;
   logic [23:0] result;
   logic        result_valid;
   logic        result_ready;
   logic        error;

   int total;
   int bad;

   vector_matrix_mult dut (
      .clk          (clk),
      .rst          (rst),
      .v            (v),
      .v_valid      (v_valid),
      .v_ready      (v_ready),
      .w            (w),
      .w_valid      (w_valid),
      .w_ready      (w_ready),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .error        (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] v;
      logic [95:0] w;
      logic [23:0] res;
      logic        err;
   } vec_t;

   vec_t tbl [8];

   function automatic logic [23:0] row3(input int a, input int b, input int c);
      return {8'(c), 8'(b), 8'(a)};
   endfunction

   function automatic logic [31:0] mkv(input int a, input int b, input int c, input int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   function automatic logic [95:0] mkw(input logic [23:0] r0, input logic [23:0] r1,
                                       input logic [23:0] r2, input logic [23:0] r3);
      return {r3, r2, r1, r0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Waits for result_valid; lat counts cycles with the capture cycle as cycle 0.
   task automatic wait_result(input string tag, output int lat);
      lat = 1;
      while (!result_valid && lat < 40) begin
         if (lat == 3) check({tag, "_err_clr_in_calc"}, {31'd0, error}, 32'd0);
         tick();
         lat++;
      end
      if (!result_valid) check({tag, "_timeout"}, {31'd0, result_valid}, 32'd1);
   endtask

   task automatic run_txn(input string tag, input logic [31:0] vv, input logic [95:0] ww,
                          input logic [23:0] er, input logic ee);
      int lat;
      v = vv;
      w = ww;
      v_valid = 1'b1;
      w_valid = 1'b1;
      result_ready = 1'b1;
      tick();
      v_valid = 1'b0;
      w_valid = 1'b0;
      check({tag, "_slots_full"}, {30'd0, v_ready, w_ready}, 32'd0);
      wait_result(tag, lat);
      check({tag, "_latency"}, lat, VL + 2);
      check({tag, "_result"}, {8'd0, result}, {8'd0, er});
      check({tag, "_error"}, {31'd0, error}, {31'd0, ee});
      tick();
      check({tag, "_valid_one_cycle"}, {31'd0, result_valid}, 32'd0);
      check({tag, "_ready_back"}, {30'd0, v_ready, w_ready}, 32'd3);
      $display("txn %s: v=%h w=%h result=%h error=%0b latency=%0d", tag, vv, ww, result, error, lat);
   endtask

   logic [95:0] w16;
   logic [31:0] v16;
   logic [23:0] r64;
   logic [31:0] vmax;
   logic [95:0] wmax;

   initial begin
      int lat;
      total = 0;
      bad = 0;
      rst = 1'b1;
      v = '0;
      w = '0;
      v_valid = 1'b0;
      w_valid = 1'b0;
      result_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      check("reset_v_ready", {31'd0, v_ready}, 32'd1);
      check("reset_w_ready", {31'd0, w_ready}, 32'd1);
      check("reset_result_valid", {31'd0, result_valid}, 32'd0);
      check("reset_error", {31'd0, error}, 32'd0);
      check("reset_result", {8'd0, result}, 32'd0);

      v16  = mkv(16, 16, 16, 16);
      w16  = mkw(row3(16, 16, 16), row3(16, 16, 16), row3(16, 16, 16), row3(16, 16, 16));
      r64  = row3(64, 64, 64);
      vmax = mkv(127, 127, 127, 127);
      wmax = mkw(row3(127, 127, 127), row3(127, 127, 127), row3(127, 127, 127), row3(127, 127, 127));

      // 4*256 = 1024 -> 64
      tbl[0] = '{v16, w16, r64, 1'b0};
      // -16*[32,-48,16] = [-512,768,-256] -> [-32,48,-16]
      tbl[1] = '{mkv(-16, 0, 0, 0), mkw(row3(32, -48, 16), 24'd0, 24'd0, 24'd0),
                 row3(-32, 48, -16), 1'b0};
      // 64516 -> 4032 = 0xFC0, low byte 0xC0, overflow
      tbl[2] = '{vmax, wmax, row3(8'hC0, 8'hC0, 8'hC0), 1'b1};
      // error cleared by the following clean transaction
      tbl[3] = '{v16, w16, r64, 1'b0};
      // col0 10*16=160->10, col1 -160->-10, col2 8*(1+4+9+16)=240->15
      tbl[4] = '{mkv(1, 2, 3, 4),
                 mkw(row3(16, -16, 8), row3(16, -16, 16), row3(16, -16, 24), row3(16, -16, 32)),
                 row3(10, -10, 15), 1'b0};
      // -128*127*4 = -65024 -> -4064 = ...F020, low byte 0x20, overflow
      tbl[5] = '{mkv(-128, -128, -128, -128), wmax, row3(32, 32, 32), 1'b1};
      // col0 2032->127 fits, col1 2048->128 overflows, col2 -2048->-128 fits
      tbl[6] = '{mkv(127, 1, 0, 0), mkw(row3(16, 16, -16), row3(0, 16, -16), 24'd0, 24'd0),
                 row3(127, 8'h80, 8'h80), 1'b1};
      // arithmetic shift floors: -1->-1, 0->0, -15->-1
      tbl[7] = '{mkv(-1, 0, 0, 0), mkw(row3(1, 0, 15), 24'd0, 24'd0, 24'd0),
                 row3(-1, 0, -1), 1'b0};

      for (int k = 0; k < 8; k++) begin
         run_txn($sformatf("tbl%0d", k), tbl[k].v, tbl[k].w, tbl[k].res, tbl[k].err);
      end

      // W offered first, v three cycles later.
      w = w16;
      w_valid = 1'b1;
      result_ready = 1'b1;
      tick();
      w_valid = 1'b0;
      check("wfirst_w_ready_low", {31'd0, w_ready}, 32'd0);
      check("wfirst_v_ready_high", {31'd0, v_ready}, 32'd1);
      tick();
      tick();
      check("wfirst_no_result_yet", {31'd0, result_valid}, 32'd0);
      v = v16;
      v_valid = 1'b1;
      tick();
      v_valid = 1'b0;
      wait_result("wfirst", lat);
      check("wfirst_latency", lat, VL + 2);
      check("wfirst_result", {8'd0, result}, {8'd0, r64});
      check("wfirst_error", {31'd0, error}, 32'd0);
      tick();
      $display("txn wfirst: result=%h latency=%0d", r64, lat);

      // Consumer stalls in DONE for 5 cycles while new operands are offered.
      v = v16;
      w = w16;
      v_valid = 1'b1;
      w_valid = 1'b1;
      result_ready = 1'b0;
      tick();
      v_valid = 1'b0;
      w_valid = 1'b0;
      wait_result("stall", lat);
      check("stall_latency", lat, VL + 2);
      for (int k = 0; k < 5; k++) begin
         v = vmax;
         w = wmax;
         v_valid = (k % 2 == 0);
         w_valid = 1'b1;
         tick();
         check($sformatf("stall_valid_%0d", k), {31'd0, result_valid}, 32'd1);
         check($sformatf("stall_result_%0d", k), {8'd0, result}, {8'd0, r64});
         check($sformatf("stall_ready_%0d", k), {30'd0, v_ready, w_ready}, 32'd0);
      end
      v_valid = 1'b0;
      w_valid = 1'b0;
      result_ready = 1'b1;
      tick();
      check("stall_release_valid", {31'd0, result_valid}, 32'd0);
      check("stall_release_ready", {30'd0, v_ready, w_ready}, 32'd3);
      check("stall_result_held", {8'd0, result}, {8'd0, r64});
      $display("txn stall: result=%h held 5 cycles", r64);

      // Reset during the second CALC cycle.
      v = vmax;
      w = wmax;
      v_valid = 1'b1;
      w_valid = 1'b1;
      tick();
      v_valid = 1'b0;
      w_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("rst_calc_valid", {31'd0, result_valid}, 32'd0);
      check("rst_calc_ready", {30'd0, v_ready, w_ready}, 32'd3);
      check("rst_calc_error", {31'd0, error}, 32'd0);
      check("rst_calc_result", {8'd0, result}, 32'd0);
      rst = 1'b0;
      $display("txn rst_calc: reset applied in CALC");

      // Reset while holding an overflowed result in DONE.
      v = vmax;
      w = wmax;
      v_valid = 1'b1;
      w_valid = 1'b1;
      result_ready = 1'b0;
      tick();
      v_valid = 1'b0;
      w_valid = 1'b0;
      wait_result("rst_done", lat);
      check("rst_done_pre_error", {31'd0, error}, 32'd1);
      rst = 1'b1;
      tick();
      check("rst_done_valid", {31'd0, result_valid}, 32'd0);
      check("rst_done_error", {31'd0, error}, 32'd0);
      check("rst_done_result", {8'd0, result}, 32'd0);
      check("rst_done_ready", {30'd0, v_ready, w_ready}, 32'd3);
      rst = 1'b0;
      $display("txn rst_done: reset applied in DONE");

      run_txn("after_rst", v16, w16, r64, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vector_matrix_mult.md
Name: vector_matrix_mult

Overview:
Backpropagation stage that consumes the delta vector produced by the elementwise-product stage. It computes the transposed-weight product result[j] = (sum over i of v[i]*W[i][j]) >>> FRACTION_WIDTH, which propagates error to the previous layer. The block processes one matrix row per cycle, with all MATRIX_WIDTH columns accumulated in parallel. It uses independent valid/ready capture of the two operands and a held result with an overflow flag.

Parameters:
VECTOR_LEN, 4, number of elements in v (matrix rows)
MATRIX_WIDTH, 3, number of matrix columns (result elements)
A_CELL_WIDTH, 8, signed width of v elements
B_CELL_WIDTH, 8, signed width of W elements
RESULT_CELL_WIDTH, 8, signed width of result elements
FRACTION_WIDTH, 4, fixed-point fraction bits (applied once, after accumulation)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
v  in  VECTOR_LEN*A_CELL_WIDTH  vector; element i at [i*A_CELL_WIDTH +: A_CELL_WIDTH]
v_valid  in  1  v offered
v_ready  out  1  v slot empty
w  in  VECTOR_LEN*MATRIX_WIDTH*B_CELL_WIDTH  matrix, row-major; W[i][j] at [(i*MATRIX_WIDTH+j)*B_CELL_WIDTH +: B_CELL_WIDTH]
w_valid  in  1  w offered
w_ready  out  1  w slot empty
result  out  MATRIX_WIDTH*RESULT_CELL_WIDTH  element j at [j*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH]
result_valid  out  1  result held
result_ready  in  1  consumer accepts
error  out  1  overflow in current/last result

Behaviour:
- All widths are signed two's complement. ACC_WIDTH = A_CELL_WIDTH + B_CELL_WIDTH + clog2(VECTOR_LEN) + 1, so the accumulator never overflows.
- Reset: state IDLE; v_set, w_set, counter, accumulators, result register and error all cleared. Outputs after reset: v_ready=1, w_ready=1, result_valid=0, error=0, result=0.
- v_ready = !v_set. w_ready = !w_set.
- A capture occurs on valid && ready. It loads the buffer and sets the flag. The two operands are captured independently, in any order or in the same cycle.
- valid while the slot is full is ignored; the held buffer is unchanged.
- IDLE: when v_set && w_set are both registered 1, go to CALC. On that edge, clear counter, accumulators and error.
- CALC: each cycle, acc[j] += v[counter]*W[counter][j] for all j, and counter increments.
- CALC lasts exactly VECTOR_LEN cycles, then the block goes to DONE.
- On the CALC->DONE edge, for each j:
  - result[j] = (acc[j] >>> FRACTION_WIDTH) truncated to RESULT_CELL_WIDTH.
  - error is set if any shifted value does not fit, i.e. its bits [ACC_WIDTH-1 : RESULT_CELL_WIDTH-1] are not all equal.
- DONE: result_valid=1, and result and error are stable. While DONE, inputs are not captured (both slots are full).
- On result_valid && result_ready: go to IDLE and clear v_set and w_set. v_ready and w_ready go to 1 the next cycle.
- result and error hold their values until the next CALC->DONE edge. error is cleared at the start of the next CALC.
- Latency: from the cycle the later operand is captured to result_valid is VECTOR_LEN+2 cycles.
- With result_ready tied high, throughput is one transaction per VECTOR_LEN+3 cycles.
- Reset mid-CALC or mid-DONE: immediate return to the reset state. The partial result is discarded and result_valid drops the next cycle.
- rst has priority over every other event in the same cycle.

Test Plan:
- v=[16,16,16,16], all W=16, result_ready=1 -> result=[64,64,64], error=0, result_valid high exactly VECTOR_LEN+2 cycles after the last capture, for one cycle.
- v=[-16,0,0,0], W row0=[32,-48,16], other rows 0 -> result=[-32,48,-16] (0xE0,0x30,0xF0), error=0.
- v all 127, W all 127 -> accumulator 64516, shifted value 4032 -> error=1. The next transaction with v=W=16 -> error=0.
- Drive w first; assert v_valid 3 cycles later -> w_ready low after its capture, and computation starts only after v is captured. Results match the first scenario.
- result_ready held low 5 cycles in DONE -> result and result_valid stable. New v_valid/w_valid pulses are ignored (ready=0). Raise ready -> IDLE, and both ready signals go high next cycle.
- Assert rst at the 2nd CALC cycle -> next cycle result_valid=0, v_ready=w_ready=1, error=0. A fresh transaction then completes correctly.
